// File: rtl/regfile_rat_pkg.sv
// Shared constants for the architectural register file and rename alias table.
// The rename tag is one bit wider than the ROB index, and its all-ones value means "no pending producer".
package regfile_rat_pkg;

  localparam int REG_NUM        = 32;
  localparam int REG_NUM_WIDTH  = 5;
  localparam int ROB_SIZE_WIDTH = 4;
  localparam logic [ROB_SIZE_WIDTH:0] NO_DEP = 5'h1F;

endpackage

// File: rtl/regfile_rat_read_port.sv
// One operand lookup: picks the value and rename tag for a single source index.
// Same-cycle commit and rename traffic is forwarded past the stored entry.
module rf_read_port #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int RS_W  = 5
) (
  input  logic             rdy,
  input  logic             flush,
  input  logic [RS_W-1:0]  rs,
  input  logic             rob_valid,
  input  logic [RS_W-1:0]  rob_rd,
  input  logic [XLEN-1:0]  rob_value,
  input  logic [TAG_W-1:0] rob_dep,
  input  logic             dec_valid,
  input  logic [RS_W-1:0]  dec_rd,
  input  logic [TAG_W-1:0] dec_dep,
  input  logic [XLEN-1:0]  reg_value,
  input  logic [TAG_W-1:0] reg_tag,
  output logic [XLEN-1:0]  value,
  output logic [TAG_W-1:0] dep
);

  localparam logic [TAG_W-1:0] NO_DEP_TAG = {TAG_W{1'b1}};

  logic rs_live_s;
  logic rob_hit_s;

  assign rs_live_s = (rs != {RS_W{1'b0}});
  assign rob_hit_s = rdy && rob_valid && (rob_rd == rs) && rs_live_s;

  // Value forwarding from the commit port
  always_comb begin
    value = reg_value;
    if (rob_hit_s) begin
      value = rob_value;
    end else begin
      value = reg_value;
    end
  end

  // Tag priority: flush, then a younger rename, then a commit that retires the current producer
  always_comb begin
    dep = reg_tag;
    if (!rs_live_s || flush) begin
      dep = NO_DEP_TAG;
    end else if (!rdy) begin
      dep = reg_tag;
    end else if (dec_valid && (dec_rd == rs)) begin
      dep = dec_dep;
    end else if (rob_hit_s && (rob_dep == reg_tag)) begin
      dep = NO_DEP_TAG;
    end else begin
      dep = reg_tag;
    end
  end

endmodule

// File: rtl/regfile_rat.sv
// Architectural register file with a register alias table of rename tags.
// Commits write values, renames write tags; a flush drops every pending tag.
module regfile_rat
  import regfile_rat_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = regfile_rat_pkg::REG_NUM,
  parameter int TAG_W   = ROB_SIZE_WIDTH + 1,
  parameter int NUM_RD  = 2,
  localparam int REG_NUM_W = $clog2(REG_NUM)
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        need_flush_in,
  input  logic                        rob_valid,
  input  logic [REG_NUM_W-1:0]        rob_rd,
  input  logic [XLEN-1:0]             rob_value,
  input  logic [TAG_W-1:0]            rob_dependency,
  input  logic                        dec_valid,
  input  logic [REG_NUM_W-1:0]        dec_rd,
  input  logic [TAG_W-1:0]            dec_dependency,
  input  logic [NUM_RD*REG_NUM_W-1:0] rd_rs_in,
  output logic [NUM_RD*XLEN-1:0]      rd_value_out,
  output logic [NUM_RD*TAG_W-1:0]     rd_dep_out,
  input  logic [REG_NUM_W-1:0]        if_rs_jalr,
  output logic [XLEN-1:0]             value_jalr_out,
  output logic [TAG_W-1:0]            dep_jalr_out,
  output logic [REG_NUM_W:0]          pending_cnt_out
);

  localparam logic [TAG_W-1:0] NO_DEP_TAG = {TAG_W{1'b1}};

  logic [XLEN-1:0]      regs_r     [REG_NUM];
  logic [TAG_W-1:0]     tag_r      [REG_NUM];
  logic [TAG_W-1:0]     tag_next_s [REG_NUM];
  logic [REG_NUM_W:0]   cnt_next_s;
  logic [REG_NUM_W:0]   cnt_r;
  logic                 commit_s;
  logic                 rename_s;

  assign commit_s = rdy_in && rob_valid && (rob_rd != {REG_NUM_W{1'b0}});
  assign rename_s = rdy_in && dec_valid && !need_flush_in && (dec_rd != {REG_NUM_W{1'b0}});

  // Next alias-table contents; a rename applied after the commit clear so it wins on the same rd
  always_comb begin
    for (int i = 0; i < REG_NUM; i++) begin
      tag_next_s[i] = tag_r[i];
    end
    if (rdy_in && need_flush_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        tag_next_s[i] = NO_DEP_TAG;
      end
    end else begin
      if (commit_s && (tag_r[rob_rd] == rob_dependency)) begin
        tag_next_s[rob_rd] = NO_DEP_TAG;
      end else begin
        tag_next_s[rob_rd] = tag_next_s[rob_rd];
      end
      if (rename_s) begin
        tag_next_s[dec_rd] = dec_dependency;
      end else begin
        tag_next_s[dec_rd] = tag_next_s[dec_rd];
      end
    end
  end

  // Population count of pending tags after this edge
  always_comb begin
    cnt_next_s = {(REG_NUM_W+1){1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      cnt_next_s = cnt_next_s + {{REG_NUM_W{1'b0}}, (tag_next_s[i] != NO_DEP_TAG)};
    end
  end

  // State update: values, tags and pending count
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
        tag_r[i]  <= NO_DEP_TAG;
      end
      cnt_r <= {(REG_NUM_W+1){1'b0}};
    end else begin
      if (commit_s) begin
        regs_r[rob_rd] <= rob_value;
      end
      for (int i = 0; i < REG_NUM; i++) begin
        tag_r[i] <= tag_next_s[i];
      end
      cnt_r <= cnt_next_s;
    end
  end

  assign pending_cnt_out = cnt_r;

  logic [REG_NUM_W-1:0] rs_s    [NUM_RD+1];
  logic [XLEN-1:0]      value_s [NUM_RD+1];
  logic [TAG_W-1:0]     dep_s   [NUM_RD+1];

  // Operand ports first, the fetch-side JALR lookup is the last instance
  for (genvar k = 0; k <= NUM_RD; k++) begin : g_port
    if (k < NUM_RD) begin : g_op
      assign rs_s[k] = rd_rs_in[k*REG_NUM_W +: REG_NUM_W];
      assign rd_value_out[k*XLEN +: XLEN]  = value_s[k];
      assign rd_dep_out[k*TAG_W +: TAG_W]  = dep_s[k];
    end else begin : g_jalr
      assign rs_s[k]        = if_rs_jalr;
      assign value_jalr_out = value_s[k];
      assign dep_jalr_out   = dep_s[k];
    end

    rf_read_port #(
      .XLEN  (XLEN),
      .TAG_W (TAG_W),
      .RS_W  (REG_NUM_W)
    ) u_port (
      .rdy       (rdy_in),
      .flush     (need_flush_in),
      .rs        (rs_s[k]),
      .rob_valid (rob_valid),
      .rob_rd    (rob_rd),
      .rob_value (rob_value),
      .rob_dep   (rob_dependency),
      .dec_valid (dec_valid),
      .dec_rd    (dec_rd),
      .dec_dep   (dec_dependency),
      .reg_value (regs_r[rs_s[k]]),
      .reg_tag   (tag_r[rs_s[k]]),
      .value     (value_s[k]),
      .dep       (dep_s[k])
    );
  end

endmodule

// File: tb/tb_regfile_rat.sv
// Directed-vector bench for regfile_rat with hand-computed expectations.
module tb_regfile_rat;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        need_flush_in;
  logic        rob_valid;
  logic [4:0]  rob_rd;
  logic [31:0] rob_value;
  logic [4:0]  rob_dependency;
  logic        dec_valid;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_dependency;
  logic [9:0]  rd_rs_in;
  logic [63:0] rd_value_out;
  logic [9:0]  rd_dep_out;
  logic [4:0]  if_rs_jalr;
  logic [31:0] value_jalr_out;
  logic [4:0]  dep_jalr_out;
  logic [5:0]  pending_cnt_out;

  int n_vec = 0;
  int n_err = 0;

  regfile_rat dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .need_flush_in   (need_flush_in),
    .rob_valid       (rob_valid),
    .rob_rd          (rob_rd),
    .rob_value       (rob_value),
    .rob_dependency  (rob_dependency),
    .dec_valid       (dec_valid),
    .dec_rd          (dec_rd),
    .dec_dependency  (dec_dependency),
    .rd_rs_in        (rd_rs_in),
    .rd_value_out    (rd_value_out),
    .rd_dep_out      (rd_dep_out),
    .if_rs_jalr      (if_rs_jalr),
    .value_jalr_out  (value_jalr_out),
    .dep_jalr_out    (dep_jalr_out),
    .pending_cnt_out (pending_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rdy_in = 1'b1; need_flush_in = 1'b0;
    rob_valid = 1'b0; rob_rd = 5'd0; rob_value = 32'd0; rob_dependency = 5'd0;
    dec_valid = 1'b0; dec_rd = 5'd0; dec_dependency = 5'd0;
  endtask

  task automatic rd(input int k, input logic [4:0] rs);
    rd_rs_in[k*5 +: 5] = rs;
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic commit(input logic [4:0] r, input logic [4:0] t, input logic [31:0] v);
    rob_valid = 1'b1; rob_rd = r; rob_dependency = t; rob_value = v;
  endtask

  task automatic rename(input logic [4:0] r, input logic [4:0] t);
    dec_valid = 1'b1; dec_rd = r; dec_dependency = t;
  endtask

  initial begin
    idle();
    rst_in = 1'b0;
    rd_rs_in = 10'd0;
    if_rs_jalr = 5'd0;
    // reset discards same-cycle commit and rename
    commit(5'd5, 5'd3, 32'h0000_0BAD);
    rename(5'd6, 5'd4);
    tick();
    rst_in = 1'b1; idle();
    rd(0, 5'd5); rd(1, 5'd6); if_rs_jalr = 5'd31;
    #1;
    chk("rst_val0", rd_value_out[31:0], 32'h0);
    chk("rst_dep1", {27'd0, rd_dep_out[9:5]}, 32'h1F);
    chk("rst_jalr_val", value_jalr_out, 32'h0);
    chk("rst_jalr_dep", {27'd0, dep_jalr_out}, 32'h1F);
    chk("rst_cnt", {26'd0, pending_cnt_out}, 32'd0);

    // rename then commit the same producer
    rename(5'd5, 5'd3);
    tick(); idle(); #1;
    chk("ren_dep", {27'd0, rd_dep_out[4:0]}, 32'h3);
    chk("ren_cnt", {26'd0, pending_cnt_out}, 32'd1);
    commit(5'd5, 5'd3, 32'h1234); #1;
    chk("fwd_val", rd_value_out[31:0], 32'h1234);
    chk("fwd_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    tick(); idle(); #1;
    chk("cmt_val", rd_value_out[31:0], 32'h1234);
    chk("cmt_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("cmt_cnt", {26'd0, pending_cnt_out}, 32'd0);

    // stale commit must not clear a younger rename
    rename(5'd5, 5'd3); tick(); idle();
    rename(5'd5, 5'd7); tick(); idle(); #1;
    chk("ren2_cnt", {26'd0, pending_cnt_out}, 32'd1);
    commit(5'd5, 5'd3, 32'hAA); #1;
    chk("stale_fwd_val", rd_value_out[31:0], 32'hAA);
    chk("stale_fwd_dep", {27'd0, rd_dep_out[4:0]}, 32'h7);
    tick(); idle(); #1;
    chk("stale_val", rd_value_out[31:0], 32'hAA);
    chk("stale_dep", {27'd0, rd_dep_out[4:0]}, 32'h7);
    chk("stale_cnt", {26'd0, pending_cnt_out}, 32'd1);

    // same-cycle rename forwarding on port 1
    rename(5'd6, 5'd2); rd(1, 5'd6); #1;
    chk("ren_fwd_dep1", {27'd0, rd_dep_out[9:5]}, 32'h2);
    tick(); idle(); #1;
    chk("ren6_cnt", {26'd0, pending_cnt_out}, 32'd2);

    // x0 ignores writes and renames
    commit(5'd0, 5'd0, 32'hFF); rename(5'd0, 5'd9); rd(0, 5'd0); #1;
    chk("x0_fwd_val", rd_value_out[31:0], 32'h0);
    chk("x0_fwd_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    tick(); idle(); #1;
    chk("x0_val", rd_value_out[31:0], 32'h0);
    chk("x0_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("x0_cnt", {26'd0, pending_cnt_out}, 32'd2);

    // commit and rename to the same rd: value written, rename tag wins
    commit(5'd6, 5'd2, 32'h55); rename(5'd6, 5'd4); #1;
    chk("both_fwd_dep", {27'd0, rd_dep_out[9:5]}, 32'h4);
    tick(); idle(); #1;
    chk("both_val", rd_value_out[63:32], 32'h55);
    chk("both_dep", {27'd0, rd_dep_out[9:5]}, 32'h4);
    chk("both_cnt", {26'd0, pending_cnt_out}, 32'd2);

    // rdy_in low: no forwarding, no state change
    rdy_in = 1'b0; rename(5'd7, 5'd4); commit(5'd8, 5'd0, 32'h77);
    rd(0, 5'd7); rd(1, 5'd8); #1;
    chk("hold_fwd_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("hold_fwd_val", rd_value_out[63:32], 32'h0);
    tick(); idle(); #1;
    chk("hold_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("hold_val", rd_value_out[63:32], 32'h0);
    chk("hold_cnt", {26'd0, pending_cnt_out}, 32'd2);

    // flush drops all tags but keeps the same-cycle commit value
    for (int i = 1; i <= 3; i++) begin
      rename(5'(i), 5'(i)); tick(); idle();
    end
    #1;
    chk("pre_flush_cnt", {26'd0, pending_cnt_out}, 32'd5);
    need_flush_in = 1'b1; commit(5'd4, 5'd0, 32'd9); rename(5'd9, 5'd5);
    rd(0, 5'd1); #1;
    chk("flush_fwd_dep", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    tick(); idle();
    rd(0, 5'd3); rd(1, 5'd9); if_rs_jalr = 5'd4; #1;
    chk("flush_dep3", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("flush_dep9", {27'd0, rd_dep_out[9:5]}, 32'h1F);
    chk("flush_val4", value_jalr_out, 32'd9);
    chk("flush_cnt", {26'd0, pending_cnt_out}, 32'd0);

    // reset mid-operation drops the in-flight commit and rename
    rename(5'd10, 5'd6); tick(); idle(); #1;
    chk("pre_rst_cnt", {26'd0, pending_cnt_out}, 32'd1);
    rst_in = 1'b0; commit(5'd4, 5'd0, 32'h99); rename(5'd11, 5'd2);
    tick(); rst_in = 1'b1; idle();
    rd(0, 5'd10); rd(1, 5'd11); #1;
    chk("rst2_dep10", {27'd0, rd_dep_out[4:0]}, 32'h1F);
    chk("rst2_dep11", {27'd0, rd_dep_out[9:5]}, 32'h1F);
    chk("rst2_val4", value_jalr_out, 32'h0);
    chk("rst2_cnt", {26'd0, pending_cnt_out}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
